spi_byte_rx: RTL and testbench
==============================

# spi_byte_rx

SPI-mode-0 slave receive deserializer that assembles one byte from the MOSI line per eight SCLK rising edges. It asserts a byte-complete flag after each byte. It sits directly behind the board SPI pins, clocked by the external SPI clock, and feeds the command/byte decoder of the SPI bridge. Back-to-back bytes within one chip-select frame are supported without deasserting chip select.

## Interface
Parameters
- none (the bit order is selected by the macro in Configuration)

Ports
- spi_sclk  input  1  SPI serial clock; the sole clock of the block; rising edge samples data.
- reset_n  input  1  Reset; asynchronous, active-low; clears all state.
- spi_cs_n  input  1  Chip select, active-low; high asynchronously aborts or clears the byte in progress.
- spi_rx  input  1  MOSI serial data; may be X or Z whenever it is not being sampled.
- rx  output  8  Most recently assembled byte; valid whenever done=1.
- done  output  1  Byte-complete flag; high from the 8th rising edge of a byte until the next byte starts.

## Operation
- State
  - 8-bit shift register, which drives rx.
  - 3-bit bit counter, 0..7, wrapping.
  - done register.
- Each spi_sclk rising edge with spi_cs_n=0 and reset_n=1:
  - shift spi_rx into the shift register (MSB-first: shift left, new bit enters at bit 0);
  - increment the bit counter modulo 8;
  - set done=1 when the counter was 7 (8th bit of the byte); otherwise set done=0.
- First rising edge of the next byte clears done. Bytes are contiguous; there are no gap cycles.
- spi_cs_n=1 (asynchronous):
  - counter=0 and done=0, held while spi_cs_n is high;
  - the shift register/rx retains its last value.
  - On spi_cs_n falling, the next rising edge is bit 0 of a new byte, so a partial byte is discarded.
- reset_n=0 (asynchronous, takes priority over everything):
  - counter=0, done=0, rx=8'h00.
- Reset values: rx=8'h00, done=0.

## Timing
- Latency: rx holds the complete byte and done=1 immediately after the 8th rising edge; rx and done update on the same edge.
  - rx must never change while done=1 except on the edge that clears done.
  - A consumer may sample rx on posedge done.
- done stays high through the falling edge after bit 7 and any idle time with spi_cs_n low and no SCLK.
- The falling edge of spi_sclk has no effect.
- Setup/hold: spi_rx must be stable around the rising spi_sclk edge. Its value between edges is don't-care.
- Simultaneous events: reset_n low overrides spi_cs_n high; spi_cs_n high overrides a coincident SCLK rising edge (the bit is ignored).
- reset_n or spi_cs_n asserted mid-byte: done drops within the same timestep and the bit count restarts.

## Configuration
- SPI_BYTE_LSB_FIRST_EN
  - Undefined (default): MSB-first; the first bit received lands in rx[7].
  - Defined: LSB-first; shift right with the new bit entering at bit 7, so the first bit received lands in rx[0].
  - Counter, done, chip-select and reset behaviour are identical in both modes.

## Test plan
- Power-on: reset_n pulsed low then high, no SCLK -> done=0, rx=8'h00.
- Single frame of two bytes, MSB-first: spi_cs_n low, clock 8'b11011010 then 8'b01011011 -> done=0 after both the rising and falling edges of bits 0..6 of each byte; done=1 after both edges of bit 7; rx=8'hDA at the first done and 8'h5B at the second.
- End of frame: spi_rx driven X, then spi_cs_n high -> done=0 within the same timestep, rx still 8'h5B.
- Resync: clock 3 bits, toggle spi_cs_n high then low, clock 8'hA5 -> done asserts exactly on the 8th edge after the toggle, rx=8'hA5.
- Mid-byte reset: clock 5 bits of 8'hFF, pulse reset_n low -> done=0, rx=8'h00; then clock 8'h3C -> rx=8'h3C with done=1 on the 8th edge.
- SPI_BYTE_LSB_FIRST_EN defined: shift in the bit sequence 0,1,0,1,1,0,1,1 -> rx=8'hDA on the 8th edge.

Source files
------------

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: SPI mode-0 slave receive deserializer; one byte per eight SCLK rising edges.
// Bit order macro: define SPI_BYTE_LSB_FIRST_EN for LSB-first, leave undefined for MSB-first.
module spi_byte_rx (
    input  logic       spi_sclk,
    input  logic       reset_n,
    input  logic       spi_cs_n,
    input  logic       spi_rx,
    output logic [7:0] rx,
    output logic       done
);

    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [2:0] bit_cnt;
    logic       frame_rst_n;

    // Chip select high clears the byte framing asynchronously but must not touch the data.
    assign frame_rst_n = reset_n & ~spi_cs_n;

`ifdef SPI_BYTE_LSB_FIRST_EN
    assign shift_d = {spi_rx, shift_q[7:1]};
`else
    assign shift_d = {shift_q[6:0], spi_rx};
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge spi_sclk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
        end else if (!spi_cs_n) begin
            shift_q <= shift_d;
        end
    end

    always_ff @(posedge spi_sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            done    <= (bit_cnt == 3'd7);
        end
    end

    assign rx = shift_q;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench for spi_byte_rx: directed vector table, test-plan sequences, random frames.
// Compile with +define+SPI_BYTE_LSB_FIRST_EN to exercise the LSB-first build.
module tb_spi_byte_rx;

    logic       spi_sclk;
    logic       reset_n;
    logic       spi_cs_n;
    logic       spi_rx;
    logic [7:0] rx;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: history of sampled bits and count of bits since frame start.
    logic hist[$];
    int   frame_bits;

    typedef struct {
        logic [7:0] seq;     // seq[7] is sent first
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    spi_byte_rx dut (
        .spi_sclk (spi_sclk),
        .reset_n  (reset_n),
        .spi_cs_n (spi_cs_n),
        .spi_rx   (spi_rx),
        .rx       (rx),
        .done     (done)
    );

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] model_rx();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) begin
            int idx = hist.size() - 1 - i;
            if (idx >= 0) begin
`ifdef SPI_BYTE_LSB_FIRST_EN
                v[7-i] = hist[idx];
`else
                v[i] = hist[idx];
`endif
            end
        end
        return v;
    endfunction

    function automatic logic model_done();
        return (frame_bits > 0) && (frame_bits % 8 == 0);
    endfunction

    task automatic model_reset();
        hist.delete();
        frame_bits = 0;
    endtask

    task automatic send_bit(input logic b);
        spi_rx = b;
        #4 spi_sclk = 1'b1;
        if (reset_n && !spi_cs_n) begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
            frame_bits++;
        end
        #1;
        check("rise_rx", rx, model_rx());
        check("rise_done", {7'd0, done}, {7'd0, model_done()});
        #4 spi_sclk = 1'b0;
        #1;
        check("fall_done", {7'd0, done}, {7'd0, model_done()});
        spi_rx = 1'bx;
        #4;
    endtask

    task automatic send_byte(input logic [7:0] seq, input logic [7:0] exp_rx, input string tag);
        for (int i = 7; i >= 0; i--) send_bit(seq[i]);
        check({tag, "_rx"}, rx, exp_rx);
        check({tag, "_done"}, {7'd0, done}, 8'd1);
    endtask

    task automatic set_cs(input logic v);
        spi_cs_n = v;
        if (v) frame_bits = 0;
        #1;
    endtask

    initial begin
`ifdef SPI_BYTE_LSB_FIRST_EN
        vecs[0] = '{8'b11011010, 8'h5B};
        vecs[1] = '{8'b01011011, 8'hDA};
        vecs[2] = '{8'h01, 8'h80};
        vecs[3] = '{8'hF0, 8'h0F};
        vecs[4] = '{8'h0C, 8'h30};
`else
        vecs[0] = '{8'b11011010, 8'hDA};
        vecs[1] = '{8'b01011011, 8'h5B};
        vecs[2] = '{8'h01, 8'h01};
        vecs[3] = '{8'hF0, 8'hF0};
        vecs[4] = '{8'h0C, 8'h0C};
`endif
        vecs[5] = '{8'h00, 8'h00};

        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_rx   = 1'bx;
        reset_n  = 1'b0;
        model_reset();
        #10 reset_n = 1'b1;
        #10;
        check("por_done", {7'd0, done}, 8'd0);
        check("por_rx", rx, 8'h00);

        // One frame carrying the whole vector table back to back.
        set_cs(1'b0);
        send_byte(8'b11011010, vecs[0].exp_rx, "frame_b0");
        send_byte(8'b01011011, vecs[1].exp_rx, "frame_b1");
        for (int k = 2; k < 6; k++) send_byte(vecs[k].seq, vecs[k].exp_rx, "table");
        send_byte(8'b01011011, vecs[1].exp_rx, "frame_last");

        // Idle with chip select low: done must hold.
        #30;
        check("idle_done", {7'd0, done}, 8'd1);

        // End of frame with X on the data line.
        spi_rx = 1'bx;
        set_cs(1'b1);
        check("eof_done", {7'd0, done}, 8'd0);
        check("eof_rx", rx, vecs[1].exp_rx);

        // Resync: partial byte discarded by a chip-select toggle.
        set_cs(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        set_cs(1'b1);
        #5;
        set_cs(1'b0);
        send_byte(8'hA5, 8'hA5, "resync");

        // Mid-byte reset.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_rx", rx, 8'h00);
        #5 reset_n = 1'b1;
        #5;
        send_byte(8'h3C, 8'h3C, "post_rst");

        // Randomised frames against the reference model.
        for (int t = 0; t < 40; t++) begin
            int n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) send_bit(1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                set_cs(1'b1);
                check("rand_cs_done", {7'd0, done}, 8'd0);
                check("rand_cs_rx", rx, model_rx());
                #3;
                set_cs(1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
